ifu_fetch: RTL

- Instruction fetch stage directly downstream of the PC generator.
- Accepts the current PC, issues an instruction-memory read, and tracks in-flight requests in order.
- Buffers returned instructions with their PCs and presents them to decode over a valid/ready handshake.
- Drives the PC generator's hold input so PC only advances when a fetch is accepted; discards stale responses on redirect.

---
 rtl/ifu_fetch.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage between the PC generator and decode.
// Issues one memory read per accepted PC and tracks in-flight requests in order.
// A PC side-queue holds the address of each request that will still deliver.
// Returned instructions are buffered with their PCs for decode.
// A redirect converts every outstanding request into a kill that is dropped on return.
module ifu_fetch #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_pc_valid,
  input  logic [AW-1:0] i_pc,
  output logic          o_holding,
  input  logic          i_flush,
  output logic          o_imem_req,
  output logic [AW-1:0] o_imem_addr,
  input  logic          i_imem_gnt,
  input  logic          i_imem_rvalid,
  input  logic [DW-1:0] i_imem_rdata,
  output logic          o_inst_valid,
  output logic [DW-1:0] o_inst,
  output logic [AW-1:0] o_inst_pc,
  input  logic          i_inst_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] L_DEPTH = (CW+1)'(FIFO_DEPTH);

  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_kill_cnt;
  logic [CW-1:0] r_fifo_cnt;
  logic [PW-1:0] r_fifo_wp;
  logic [PW-1:0] r_fifo_rp;
  logic [PW-1:0] r_sq_wp;
  logic [PW-1:0] r_sq_rp;
  logic [DW-1:0] r_fifo_inst [FIFO_DEPTH];
  logic [AW-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0] r_sq_pc     [FIFO_DEPTH];

  logic          w_pop;
  logic          w_credit_ok;
  logic          w_issue;
  logic          w_rsp;
  logic          w_push;
  logic [CW:0]   w_credit_sum;

  // Handshake and credit decode. Outputs are forced idle while reset is held,
  // so nothing waits for a clock edge.
  always_comb begin
    o_inst_valid = rst_n && (r_fifo_cnt != '0) && !i_flush;
    w_pop        = o_inst_valid && i_inst_ready;
    // A slot freed by this cycle's pop may be reused immediately, which keeps
    // one fetch per cycle with a single-cycle memory.
    w_credit_sum = {1'b0, r_out_cnt} + {1'b0, r_fifo_cnt} - {{CW{1'b0}}, w_pop};
    w_credit_ok  = w_credit_sum < L_DEPTH;
    o_imem_req   = rst_n && i_pc_valid && !i_flush && w_credit_ok;
    o_imem_addr  = i_pc;
    w_issue      = o_imem_req && i_imem_gnt;
    o_holding    = !w_issue;
    // A response with nothing outstanding is a protocol error and is ignored.
    w_rsp        = i_imem_rvalid && (r_out_cnt != '0);
    w_push       = w_rsp && (r_kill_cnt == '0) && !i_flush;
    o_inst       = r_fifo_inst[r_fifo_rp];
    o_inst_pc    = r_fifo_pc[r_fifo_rp];
  end

  // Outstanding-request and kill counters. Killed requests keep their credit
  // until the memory returns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt  <= '0;
      r_kill_cnt <= '0;
    end else begin
      if (w_issue && !w_rsp) begin
        r_out_cnt <= r_out_cnt + CW'(1);
      end else if (!w_issue && w_rsp) begin
        r_out_cnt <= r_out_cnt - CW'(1);
      end
      if (i_flush) begin
        r_kill_cnt <= r_out_cnt - CW'(w_rsp);
      end else if (w_rsp && (r_kill_cnt != '0)) begin
        r_kill_cnt <= r_kill_cnt - CW'(1);
      end
    end
  end

  // Instruction FIFO and PC side-queue pointers; a redirect empties both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_wp  <= '0;
      r_fifo_rp  <= '0;
      r_fifo_cnt <= '0;
      r_sq_wp    <= '0;
      r_sq_rp    <= '0;
    end else if (i_flush) begin
      r_fifo_wp  <= '0;
      r_fifo_rp  <= '0;
      r_fifo_cnt <= '0;
      r_sq_wp    <= '0;
      r_sq_rp    <= '0;
    end else begin
      if (w_push) r_fifo_wp <= r_fifo_wp + PW'(1);
      if (w_pop)  r_fifo_rp <= r_fifo_rp + PW'(1);
      if (w_push && !w_pop) begin
        r_fifo_cnt <= r_fifo_cnt + CW'(1);
      end else if (!w_push && w_pop) begin
        r_fifo_cnt <= r_fifo_cnt - CW'(1);
      end
      if (w_issue) r_sq_wp <= r_sq_wp + PW'(1);
      if (w_push)  r_sq_rp <= r_sq_rp + PW'(1);
    end
  end

  // Data storage, no reset needed: entries are only read when marked valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_inst[r_fifo_wp] <= i_imem_rdata;
      r_fifo_pc[r_fifo_wp]   <= r_sq_pc[r_sq_rp];
    end
    if (w_issue) begin
      r_sq_pc[r_sq_wp] <= i_pc;
    end
  end

  a_rvalid_has_request: assert property (
    @(posedge clk) disable iff (!rst_n) i_imem_rvalid |-> (r_out_cnt != '0));

endmodule
